// File: rtl/cpu_pkg.sv
// Shared CPU definitions: flag bit positions and default register-file sizing.
// No logic; constants only.
// No flow control.
package cpu_pkg;

    // Bit positions inside the flags register
    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_SIGN     = 2;
    localparam int FLAG_OVERFLOW = 3;

    // Default sizing and reset values for the register file
    localparam int              DEF_DATA_W     = 8;
    localparam int              DEF_PC_W       = 16;
    localparam logic [15:0]     DEF_RESET_PC   = 16'h0000;
    localparam logic [7:0]      DEF_SP_RESET   = 8'hFF;
    localparam logic [7:0]      DEF_STACK_PAGE = 8'h01;

endpackage

// File: rtl/cpu_stack_ptr.sv
// Bounded stack pointer with push/pop, stack address generation and sticky errors.
// stack_addr is combinational from SP and the request; SP updates at the next edge.
// No backpressure: an out-of-range push/pop is dropped and flagged instead of stalled.
module cpu_stack_ptr
    import cpu_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                PC_W       = DEF_PC_W,
    parameter logic [DATA_W-1:0] SP_RESET   = DATA_W'(DEF_SP_RESET),
    parameter logic [DATA_W-1:0] STACK_PAGE = DATA_W'(DEF_STACK_PAGE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sp_push,
    input  logic              sp_pop,
    input  logic              sp_write,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] sp_out,
    output logic [PC_W-1:0]   stack_addr,
    output logic              stack_ovf,
    output logic              stack_unf
);

    localparam int PAGE_W = PC_W - DATA_W;
    localparam logic [PAGE_W-1:0] PAGE_BITS = PAGE_W'(STACK_PAGE);

    logic [DATA_W-1:0] sp_q;
    logic              ovf_q;
    logic              unf_q;
    logic              push_only;
    logic              pop_only;
    logic              ovf_evt;
    logic              unf_evt;
    logic [DATA_W-1:0] sp_plus1;

    // A simultaneous push and pop cancels out: no move, no error.
    assign push_only = sp_push & ~sp_pop;
    assign pop_only  = sp_pop & ~sp_push;
    assign sp_plus1  = sp_q + DATA_W'(1);

    // An explicit SP write overrides the stack operation, so no error is raised then.
    assign ovf_evt = ~sp_write & push_only & (sp_q == '0);
    assign unf_evt = ~sp_write & pop_only & (sp_q == SP_RESET);

    // Pop reads the slot above SP; push and idle address the slot at SP.
    assign stack_addr = pop_only ? {PAGE_BITS, sp_plus1} : {PAGE_BITS, sp_q};

    // SP register and sticky errors; a new error beats err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= SP_RESET;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (sp_write) begin
                sp_q <= wr_data;
            end else if (push_only && !ovf_evt) begin
                sp_q <= sp_q - DATA_W'(1);
            end else if (pop_only && !unf_evt) begin
                sp_q <= sp_plus1;
            end
            ovf_q <= ovf_evt | (ovf_q & ~err_clr);
            unf_q <= unf_evt | (unf_q & ~err_clr);
        end
    end

    assign sp_out    = sp_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule

// File: rtl/cpu_regfile_param.sv
// CPU register file: GPR bank (2R/1W), PC unit, stack pointer, flags and IR.
// Reads are zero-latency combinational; all state updates at the next rising edge.
// No backpressure; REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module cpu_regfile_param
    import cpu_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                NUM_REGS   = 4,
    parameter int                RADDR_W    = 2,
    parameter int                PC_W       = DEF_PC_W,
    parameter logic [PC_W-1:0]   RESET_PC   = PC_W'(DEF_RESET_PC),
    parameter logic [DATA_W-1:0] SP_RESET   = DATA_W'(DEF_SP_RESET),
    parameter logic [DATA_W-1:0] STACK_PAGE = DATA_W'(DEF_STACK_PAGE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0]  rd_data_a,
    input  logic [RADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]  rd_data_b,
    input  logic               wr_en,
    input  logic [RADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               pc_inc,
    input  logic               pc_load,
    input  logic [PC_W-1:0]    pc_load_val,
    input  logic               pc_rel,
    input  logic [DATA_W-1:0]  pc_offset,
    output logic [PC_W-1:0]    pc_out,
    input  logic               sp_push,
    input  logic               sp_pop,
    input  logic               sp_write,
    output logic [DATA_W-1:0]  sp_out,
    output logic [PC_W-1:0]    stack_addr,
    output logic               stack_ovf,
    output logic               stack_unf,
    input  logic               err_clr,
    input  logic               ir_write,
    output logic [DATA_W-1:0]  ir_out,
    input  logic [DATA_W-1:0]  flags_mask,
    input  logic [DATA_W-1:0]  flags_in,
    output logic [DATA_W-1:0]  flags_out
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] flags_q;
    logic              wr_vld;
    logic [PC_W-1:0]   pc_offset_sext;

    // Addresses beyond the populated bank are ignored on write.
    assign wr_vld = wr_en && (int'(wr_addr) < NUM_REGS);

    assign pc_offset_sext = {{(PC_W-DATA_W){pc_offset[DATA_W-1]}}, pc_offset};

    // GPR bank write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_vld) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Read ports: unpopulated addresses return zero, optional write-through forwarding
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (int'(rd_addr_a) < NUM_REGS) begin
            rd_data_a = regs_q[rd_addr_a];
        end
        if (int'(rd_addr_b) < NUM_REGS) begin
            rd_data_b = regs_q[rd_addr_b];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_vld && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
        if (wr_vld && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
`endif
    end

    // Program counter: load beats relative branch beats increment; wraps modulo 2**PC_W
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (pc_load) begin
            pc_q <= pc_load_val;
        end else if (pc_rel) begin
            pc_q <= pc_q + pc_offset_sext;
        end else if (pc_inc) begin
            pc_q <= pc_q + PC_W'(1);
        end
    end

    // Instruction register and per-bit masked flags update
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            if (ir_write) begin
                ir_q <= wr_data;
            end
            flags_q <= (flags_q & ~flags_mask) | (flags_in & flags_mask);
        end
    end

    cpu_stack_ptr #(
        .DATA_W     (DATA_W),
        .PC_W       (PC_W),
        .SP_RESET   (SP_RESET),
        .STACK_PAGE (STACK_PAGE)
    ) u_stack_ptr (
        .clk        (clk),
        .reset      (reset),
        .sp_push    (sp_push),
        .sp_pop     (sp_pop),
        .sp_write   (sp_write),
        .wr_data    (wr_data),
        .err_clr    (err_clr),
        .sp_out     (sp_out),
        .stack_addr (stack_addr),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
    );

    assign pc_out    = pc_q;
    assign ir_out    = ir_q;
    assign flags_out = flags_q;

endmodule

// File: doc/cpu_regfile_param.md
Name: cpu_regfile_param

Overview:
Parametrised successor to the CPU register file. It holds a configurable bank of general-purpose registers with two read ports and one write port. It also contains a program-counter unit with increment, absolute-load and signed-relative branch, a bounded stack-pointer unit with push/pop and sticky overflow/underflow errors, a masked flags register and the instruction register. The control unit drives it, and it feeds the ALU and the address-generation logic.

Parameters:
DATA_W, 8, width of GPRs, SP, IR, flags and branch offset
NUM_REGS, 4, number of general-purpose registers (2..16)
RADDR_W, 2, register-address width, must satisfy 2**RADDR_W >= NUM_REGS
PC_W, 16, program-counter and address width
RESET_PC, 16'h0000, PC value after reset
SP_RESET, 8'hFF, SP value after reset (empty stack)
STACK_PAGE, 8'h01, upper address bits of stack accesses

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
rd_addr_a  in  RADDR_W  read port A select
rd_data_a  out  DATA_W  read port A data (combinational)
rd_addr_b  in  RADDR_W  read port B select
rd_data_b  out  DATA_W  read port B data (combinational)
wr_en  in  1  GPR write enable
wr_addr  in  RADDR_W  GPR write select
wr_data  in  DATA_W  GPR write data
pc_inc  in  1  PC += 1
pc_load  in  1  PC <= pc_load_val
pc_load_val  in  PC_W  absolute target
pc_rel  in  1  PC += sign-extended pc_offset
pc_offset  in  DATA_W  two's-complement branch offset
pc_out  out  PC_W  current PC
sp_push  in  1  push request
sp_pop  in  1  pop request
sp_write  in  1  SP <= wr_data
sp_out  out  DATA_W  current SP
stack_addr  out  PC_W  stack memory address for this cycle (combinational)
stack_ovf  out  1  sticky: push attempted with SP==0
stack_unf  out  1  sticky: pop attempted with SP==SP_RESET
err_clr  in  1  clears both sticky errors
ir_write  in  1  IR <= wr_data
ir_out  out  DATA_W  instruction register
flags_mask  in  DATA_W  per-bit flag update enables
flags_in  in  DATA_W  new flag values
flags_out  out  DATA_W  flags register

Behaviour:
- Reset (synchronous, highest priority) sets: GPRs=0, pc_out=RESET_PC, sp_out=SP_RESET, ir_out=0, flags_out=0, stack_ovf=stack_unf=0. rd_data_a/b follow the cleared GPRs.
- Reads are combinational with zero latency. An address >= NUM_REGS reads 0.
- GPR writes take effect at the next rising edge. A write with wr_addr >= NUM_REGS is ignored.
- PC priority is pc_load > pc_rel > pc_inc, otherwise hold. Relative branch: PC <= PC + sext(pc_offset). All PC arithmetic wraps modulo 2**PC_W (16'hFFFF+1 gives 0; 16'h0002 with offset 8'hFC gives 16'hFFFE).
- SP priority is sp_write > push/pop.
  - Push only: stack_addr={STACK_PAGE,SP}, then SP-1 at the edge.
  - Pop only: stack_addr={STACK_PAGE,SP+1}, then SP+1 at the edge.
  - Push and pop together: SP unchanged, stack_addr={STACK_PAGE,SP}, no error.
  - Push at SP==0: SP holds and stack_ovf sets. Pop at SP==SP_RESET: SP holds and stack_unf sets.
  - Idle: stack_addr={STACK_PAGE,SP}. STACK_PAGE is zero-extended or truncated to fill PC_W-DATA_W bits.
- Sticky errors: a new error event in the same cycle as err_clr wins (bit stays set).
- Flags: flags <= (flags & ~flags_mask) | (flags_in & flags_mask). A mask of all zeros holds the flags.
- IR loads wr_data when ir_write=1. wr_data is shared by GPR, SP and IR writes, and these may occur in the same cycle.
- Reset asserted mid-sequence, for example during a push: the reset values win and no error is recorded.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wr_en=1, the write address is valid, and rd_addr_x==wr_addr, rd_data_x returns wr_data in the same cycle (write-through forwarding).
- Undefined: reads return the stored value, and the new data appears the cycle after the write.

Decomposition:
- Shared package cpu_pkg: flag bit indices (CARRY, ZERO, SIGN, OVERFLOW), default DATA_W/PC_W, RESET_PC, SP_RESET, STACK_PAGE constants.
- One natural sub-module, cpu_stack_ptr: SP register, push/pop arithmetic, stack_addr generation and the sticky errors. Instantiated once.

Test Plan:
- Reset, then write r2=8'hA5 and r3=8'h3C; read A=2, B=3 -> A5/3C the next cycle. With BYPASS, A5 appears in the write cycle.
- PC=16'h0010: pc_inc -> 0011; pc_rel with 8'hF0 -> 0001; pc_load=16'hFFFF plus pc_inc in the same cycle -> FFFF; pc_inc -> 0000.
- Starting from SP=FF: three pushes give stack_addr 01FF, 01FE, 01FD and SP=FC. Three pops give stack_addr 01FD, 01FE, 01FF and SP=FF. A fourth pop keeps SP=FF and sets stack_unf=1.
- sp_write 8'h00 then push -> SP stays 00 and stack_ovf=1. err_clr -> 0. Push and err_clr together -> stack_ovf remains 1.
- flags=8'h00; flags_in=8'hFF with mask 8'h05 -> 05; then flags_in=8'h00 with mask 8'h01 -> 04.
- Reset asserted in the same cycle as wr_en, push and pc_inc -> all outputs at their reset values, sticky errors 0.
